rsa_modexp_engine: RTL and testbench

RSA_MODEXP_ENGINE -- requirements
Module: rsa_modexp_engine

---
 rtl/rsa_modexp_engine.sv | 186 ++++++++++++++++++
 tb/tb_rsa_modexp_engine.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rsa_modexp_engine.sv
// rtl/rsa_modexp_engine.sv - modular exponentiation engine, right-to-left binary method
// Interleaved shift-add modular multiplier, data-independent latency W + 2*W^2 + 1 cycles.
module rsa_modexp_engine #(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] base_i,
    input  logic [WORD_WIDTH-1:0] exp_i,
    input  logic [WORD_WIDTH-1:0] mod_i,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] result_o,
    output logic                  error_o,
    output logic                  busy_o
);

    localparam int W  = WORD_WIDTH;
    localparam int CW = $clog2(W + 1);
    localparam int IW = $clog2(W);

    typedef enum logic [2:0] {
        IDLE,
        REDUCE,
        MUL,
        SQR,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [W-1:0]  base_q;
    logic [W-1:0]  exp_q;
    logic [W-1:0]  mod_q;
    logic [W-1:0]  r_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  m_q;
    logic [W+1:0]  acc_q;
    logic [CW-1:0] cnt_q;
    logic [IW-1:0] bit_q;
    logic [W-1:0]  result_q;
    logic          error_q;

    logic          accept;
    logic          mul_last;
    logic          last_bit;
    logic [W-1:0]  one_mod_n;
    logic [W+1:0]  mod_ext;
    logic [W+1:0]  dbl;
    logic [W+1:0]  dbl_red;
    logic [W+1:0]  sum;
    logic [W+1:0]  sum_red;
    logic [W-1:0]  step_res;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy_o    = (state != IDLE);
    assign result_o  = result_q;
    assign error_o   = error_q;

    assign accept    = in_valid && in_ready;
    assign one_mod_n = (mod_q == W'(1)) ? '0 : W'(1);
    assign last_bit  = (bit_q == IW'(W - 1));
    // REDUCE spends its first cycle on setup, so its final step sits one count later
    assign mul_last  = (state == REDUCE) ? (cnt_q == CW'(W)) : (cnt_q == CW'(W - 1));

    // One multiplier step: acc = 2*acc mod N, then add a mod N when the multiplier MSB is set
    always_comb begin
        mod_ext  = {2'b00, mod_q};
        dbl      = acc_q << 1;
        dbl_red  = (dbl >= mod_ext) ? (dbl - mod_ext) : dbl;
        sum      = dbl_red + (m_q[W-1] ? {2'b00, a_q} : '0);
        sum_red  = (sum >= mod_ext) ? (sum - mod_ext) : sum;
        step_res = sum_red[W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (mod_i == '0) ? DONE : REDUCE;
            REDUCE:  if (mul_last) state_nxt = MUL;
            MUL:     if (mul_last) state_nxt = SQR;
            SQR:     if (mul_last) state_nxt = last_bit ? DONE : MUL;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q   <= '0;
            exp_q    <= '0;
            mod_q    <= '0;
            r_q      <= '0;
            b_q      <= '0;
            a_q      <= '0;
            m_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            bit_q    <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        base_q   <= base_i;
                        exp_q    <= exp_i;
                        mod_q    <= mod_i;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        bit_q    <= '0;
                        result_q <= '0;
                        error_q  <= (mod_i == '0);
                    end
                end
                REDUCE: begin
                    if (cnt_q == '0) begin
                        // base may exceed N, so it drives the multiplier bits against a = 1 mod N
                        r_q   <= one_mod_n;
                        a_q   <= one_mod_n;
                        m_q   <= base_q;
                        acc_q <= '0;
                        cnt_q <= CW'(1);
                    end else if (mul_last) begin
                        b_q   <= step_res;
                        a_q   <= step_res;
                        m_q   <= r_q;
                        acc_q <= '0;
                        cnt_q <= '0;
                    end else begin
                        acc_q <= sum_red;
                        m_q   <= m_q << 1;
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                MUL: begin
                    if (mul_last) begin
                        if (exp_q[0]) r_q <= step_res;
                        exp_q <= exp_q >> 1;
                        a_q   <= b_q;
                        m_q   <= b_q;
                        acc_q <= '0;
                        cnt_q <= '0;
                    end else begin
                        acc_q <= sum_red;
                        m_q   <= m_q << 1;
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                SQR: begin
                    if (mul_last) begin
                        b_q   <= step_res;
                        acc_q <= '0;
                        cnt_q <= '0;
                        if (last_bit) begin
                            result_q <= r_q;
                        end else begin
                            bit_q <= bit_q + IW'(1);
                            a_q   <= step_res;
                            m_q   <= r_q;
                        end
                    end else begin
                        acc_q <= sum_red;
                        m_q   <= m_q << 1;
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_modexp_engine.sv
// tb/tb_rsa_modexp_engine.sv - self-checking bench for rsa_modexp_engine
// Reference model uses 64-bit integer square-and-multiply; directed vectors pin it.
module tb_rsa_modexp_engine;

    localparam int W   = 32;
    localparam int LAT = W + 2 * W * W + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] base_i = '0;
    logic [W-1:0] exp_i = '0;
    logic [W-1:0] mod_i = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result_o;
    logic         error_o;
    logic         busy_o;

    int           checks = 0;
    int           failures = 0;
    bit           started = 1'b0;
    bit           exp_pending = 1'b0;
    logic [W-1:0] exp_res = '0;
    logic         exp_err = 1'b0;

    rsa_modexp_engine #(.WORD_WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .base_i    (base_i),
        .exp_i     (exp_i),
        .mod_i     (mod_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result_o  (result_o),
        .error_o   (error_o),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint unsigned act, input longint unsigned req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [W-1:0] b, input logic [W-1:0] e,
                                           input logic [W-1:0] n);
        longint unsigned m, r, bb;
        if (n == 0) return '0;
        m  = longint'(n);
        r  = 1 % m;
        bb = longint'(b) % m;
        for (int i = 0; i < W; i++) begin
            if (e[i]) r = (r * bb) % m;
            bb = (bb * bb) % m;
        end
        return r[W-1:0];
    endfunction

    // Continuous checks on every cycle outside reset
    always @(negedge clk) begin
        if (started && !rst) begin
            check("ready_valid_exclusive", in_ready && out_valid, 0);
            check("busy_vs_idle", busy_o, !in_ready);
            if (out_valid) begin
                check("unexpected_out_valid", exp_pending, 1);
                check("stream_result", result_o, exp_res);
                check("stream_error", error_o, exp_err);
            end
        end
    end

    task automatic run_req(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] n,
                           input logic [W-1:0] lit_res, input logic lit_err, input int lat,
                           input int hold, input bit poke);
        int guard;
        int n_cyc;
        exp_res = model(b, e, n);
        exp_err = (n == 0);
        check("model_vs_literal", exp_res, lit_res);
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("in_ready_before_req", in_ready, 1);
        base_i      = b;
        exp_i       = e;
        mod_i       = n;
        in_valid    = 1'b1;
        exp_pending = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        base_i   = $urandom;
        exp_i    = $urandom;
        mod_i    = $urandom;
        n_cyc    = 0;
        while (!out_valid && n_cyc < LAT + 200) begin
            if (poke) in_valid = (n_cyc % 97 == 5);
            @(posedge clk);
            #1;
            n_cyc++;
        end
        in_valid = 1'b0;
        check("latency", n_cyc, lat);
        check("result", result_o, lit_res);
        check("error", error_o, lit_err);
        for (int i = 0; i < hold; i++) begin
            if (poke) in_valid = (i % 2 == 0);
            @(posedge clk);
            #1;
            check("hold_out_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_result", result_o, lit_res);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready   = 1'b0;
        exp_pending = 1'b0;
        check("in_ready_after_handoff", in_ready, 1);
        check("out_valid_after_handoff", out_valid, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_error"}, error_o, 0);
        check({tag, "_result"}, result_o, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst     = 1'b0;
        started = 1'b1;

        run_req(32'd2, 32'd5, 32'd3233, 32'd32, 1'b0, LAT, 0, 1'b0);
        run_req(32'd65, 32'd17, 32'd3233, 32'd2790, 1'b0, LAT, 0, 1'b0);
        run_req(32'd2790, 32'd413, 32'd3233, 32'd65, 1'b0, LAT, 0, 1'b0);
        run_req(32'd77, 32'd9, 32'd0, 32'd0, 1'b1, 0, 0, 1'b0);
        run_req(32'd123, 32'd0, 32'd3233, 32'd1, 1'b0, LAT, 0, 1'b0);
        run_req(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, LAT, 0, 1'b0);
        run_req(32'd12345, 32'd7, 32'd1, 32'd0, 1'b0, LAT, 0, 1'b0);
        run_req(32'd3238, 32'd3, 32'd3233, 32'd125, 1'b0, LAT, 10, 1'b1);

        // Reset in the middle of a request abandons it
        exp_res  = 32'd2790;
        exp_err  = 1'b0;
        base_i   = 32'd65;
        exp_i    = 32'd17;
        mod_i    = 32'd3233;
        in_valid = 1'b1;
        exp_pending = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (1000) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        exp_pending = 1'b0;
        check_reset_outputs("midrun_reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("no_valid_after_reset", out_valid, 0);
        run_req(32'd65, 32'd17, 32'd3233, 32'd2790, 1'b0, LAT, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
